// File: rtl/rx_autobaud.sv
// Receive-line front end: synchronises and deglitches rx, and measures the
// bit period of a 0x55 sync character to publish a run-time baud divisor.
module rx_autobaud #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 271,
  parameter int MIN_DIV     = 16,
  parameter int FILTER_LEN  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 relearn,
  output logic                 rx_out,
  output logic [DIV_WIDTH-1:0] div_out,
  output logic                 div_valid,
  output logic                 sync_err
);

  localparam int CW = DIV_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  logic       sync1_reg, sync2_reg;
  logic [2:0] run_reg;
  logic       rx_reg, rx_prev_reg;
  logic       fall, edge_seen;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [CW-1:0]        last_reg, last_next;
  logic [CW-1:0]        ref_reg, ref_next;
  logic [3:0]           edges_reg, edges_next;
  logic [DIV_WIDTH-1:0] cand_reg, cand_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic                 valid_reg, valid_next;
  logic                 err_reg, err_next;

  logic [CW-1:0] iv, diff, tol;
  logic [CW:0]   cnt_round;
  logic [3:0]    edges_inc;

  // The filter only moves rx_reg after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      run_reg     <= '0;
      rx_reg      <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= rx_in;
      sync2_reg   <= sync1_reg;
      rx_prev_reg <= rx_reg;
      if (sync2_reg == rx_reg) begin
        run_reg <= '0;
      end else if (run_reg == 3'(FILTER_LEN - 1)) begin
        run_reg <= '0;
        rx_reg  <= ~rx_reg;
      end else begin
        run_reg <= run_reg + 3'd1;
      end
    end
  end

  assign fall      = rx_prev_reg & ~rx_reg;
  assign edge_seen = rx_prev_reg ^ rx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= '0;
      ref_reg   <= '0;
      edges_reg <= '0;
      cand_reg  <= '0;
      div_reg   <= DIV_WIDTH'(DEFAULT_DIV);
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      ref_reg   <= ref_next;
      edges_reg <= edges_next;
      cand_reg  <= cand_next;
      div_reg   <= div_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    ref_next   = ref_reg;
    edges_next = edges_reg;
    cand_next  = cand_reg;
    div_next   = div_reg;
    valid_next = valid_reg;
    err_next   = 1'b0;

    iv        = cnt_reg - last_reg;
    diff      = (iv >= ref_reg) ? (iv - ref_reg) : (ref_reg - iv);
    tol       = ref_reg >> 2;
    edges_inc = edges_reg + 4'd1;
    // Eight bit times rounded to the nearest whole divisor.
    cnt_round = {1'b0, cnt_reg} + (CW + 1)'(4);

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next = MEASURE;
          cnt_next   = '0;
          last_next  = '0;
          edges_next = '0;
        end
      end
      MEASURE: begin
        // Saturation wins over a coincident edge so a stuck line always aborts.
        if (cnt_reg == '1) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (edge_seen) begin
            last_next  = cnt_reg;
            edges_next = edges_inc;
            if (edges_inc == 4'd1) begin
              ref_next = iv;
            end else if (diff > tol) begin
              err_next   = 1'b1;
              state_next = IDLE;
            end else if (edges_inc == 4'd8) begin
              cand_next = cnt_round[DIV_WIDTH+2:3];
            end else if (edges_inc == 4'd9) begin
              if (cand_reg >= DIV_WIDTH'(MIN_DIV)) begin
                div_next   = cand_reg;
                valid_next = 1'b1;
                state_next = LOCKED;
              end else begin
                err_next   = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
      end
      LOCKED: begin
        if (relearn) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_out    = rx_reg;
  assign div_out   = div_reg;
  assign div_valid = valid_reg;
  assign sync_err  = err_reg;

endmodule

// File: tb/tb_rx_autobaud.sv
// Bench for rx_autobaud: directed scenarios plus random characters, checked
// against an edge-event model of the measurement rules.
module tb_rx_autobaud;

  localparam int DW   = 9;
  localparam int DEF  = 271;
  localparam int MIN  = 16;
  localparam int FL   = 3;
  localparam int SAT  = (1 << (DW + 3)) - 1;
  localparam int LAT  = 2 + FL + 1;       // rx_in edge to FSM action
  localparam int T_TO = LAT + SAT + 1;    // rx_in fall to sync_err on a stuck line

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          relearn = 1'b0;
  logic          rx_out;
  logic [DW-1:0] div_out;
  logic          div_valid;
  logic          sync_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_wide = 0;
  logic err_prev = 1'b0;
  logic [7:0] hist = 8'hFF;

  // Model state: 0 idle, 1 measuring, 2 locked.
  int m_state = 0;
  int m_s = 0, m_last = 0, m_ref = 0, m_edges = 0, m_cand = 0;
  int m_div = DEF, m_valid = 0, m_err = 0;

  rx_autobaud #(
    .DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .MIN_DIV(MIN), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .relearn(relearn),
    .rx_out(rx_out), .div_out(div_out), .div_valid(div_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    hist     <= {hist[6:0], rx_in};
    err_seen <= err_seen + int'(sync_err);
    err_wide <= err_wide + ((sync_err && err_prev) ? 1 : 0);
    err_prev <= sync_err;
  end

  // Edge at rx_in cycle t; counter value seen by that edge is t - start - 1.
  task automatic model_edge(input int t, input bit is_fall);
    int cnt, iv, d;
    cnt = t - m_s - 1;
    if (m_state == 1 && cnt >= SAT) begin
      m_err++;
      m_state = 0;
      if (cnt == SAT) return;
    end
    if (m_state == 0) begin
      if (is_fall) begin
        m_state = 1; m_s = t; m_last = 0; m_edges = 0;
      end
    end else if (m_state == 1) begin
      iv = cnt - m_last;
      m_last = cnt;
      m_edges++;
      if (m_edges == 1) begin
        m_ref = iv;
      end else begin
        d = (iv > m_ref) ? iv - m_ref : m_ref - iv;
        if (d > m_ref / 4) begin
          m_err++; m_state = 0; return;
        end
        if (m_edges == 8) m_cand = ((cnt + 4) / 8) % (1 << DW);
        if (m_edges == 9) begin
          if (m_cand >= MIN) begin
            m_div = m_cand; m_valid = 1; m_state = 2;
          end else begin
            m_err++; m_state = 0;
          end
        end
      end
    end
  endtask

  task automatic model_timeout(input int now);
    if (m_state == 1 && m_s + T_TO <= now) begin
      m_err++;
      m_state = 0;
    end
  endtask

  task automatic step(input logic v);
    @(posedge clk); #1;
    if (v !== rx_in) begin
      rx_in = v;
      model_edge(cyc, !v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(rx_in);
  endtask

  // Let the last edge propagate and stay clear of a timeout on the sampling boundary.
  task automatic settle();
    idle(12);
    while (m_state == 1 && m_s + T_TO >= cyc - 3 && m_s + T_TO <= cyc + 1) step(rx_in);
    model_timeout(cyc);
    @(negedge clk);
  endtask

  task automatic drain();
    while (m_state == 1 && cyc < m_s + T_TO + 4) step(rx_in);
    settle();
  endtask

  task automatic pulse_relearn();
    @(posedge clk); #1 relearn = 1'b1;
    @(posedge clk); #1 relearn = 1'b0;
    if (m_state == 2) m_state = 0;
  endtask

  task automatic rst_assert();
    @(posedge clk); #1;
    rst = 1'b1;
    rx_in = 1'b1;
    m_state = 0; m_div = DEF; m_valid = 0;
  endtask

  task automatic rst_release();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // 8N1 frame, LSB first; boundary 8 is never jittered so the divisor stays exact.
  task automatic send_char(input logic [7:0] c, input int p, input int jit,
                           input bit mirror, input int nbits);
    logic [9:0] frame;
    int bnd[10];
    int b;
    frame = {1'b1, c, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bnd[i] = i * p;
      if (i != 0 && i != 8 && jit > 0) bnd[i] += int'($urandom_range(2 * jit)) - jit;
    end
    for (int k = 0; k < nbits * p; k++) begin
      b = 0;
      for (int i = 1; i < 10; i++) if (k >= bnd[i]) b = i;
      step(frame[b]);
      if (mirror) begin
        @(negedge clk);
        vectors++;
        if (rx_out !== hist[4]) begin
          miscompares++;
          $display("FAIL mirror cyc %0d: rx_out %b expected %b", cyc, rx_out, hist[4]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors += 4;
    if (rx_out !== 1'b1) begin miscompares++; $display("FAIL reset_rx_out: got %b expected 1", rx_out); end
    if (div_out !== DW'(DEF)) begin miscompares++; $display("FAIL reset_div: got %0d expected %0d", div_out, DEF); end
    if (div_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", div_valid); end
    if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", sync_err); end
    rst_release();
    $display("test_reset done");
  endtask

  task automatic test_glitch();
    int low_cnt = 0;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1 rx_in = (k < 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        vectors++;
        if (rx_out !== 1'b1) begin
          miscompares++;
          $display("FAIL glitch2 pulse %0d cyc %0d: rx_out %b expected 1", g, k, rx_out);
        end
      end
    end
    vectors++;
    if (err_seen !== m_err) begin miscompares++; $display("FAIL glitch_err: got %0d expected %0d", err_seen, m_err); end
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1 rx_in = (k < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rx_out === 1'b0) low_cnt++;
    end
    vectors++;
    if (low_cnt != 3) begin miscompares++; $display("FAIL glitch3_width: got %0d expected 3", low_cnt); end
    rst_assert();
    idle(3);
    rst_release();
    $display("test_glitch done");
  endtask

  task automatic test_basic_lock();
    idle(20);
    send_char(8'h55, 271, 0, 1'b1, 10);
    settle();
    vectors += 3;
    if (div_out !== 9'd271) begin miscompares++; $display("FAIL basic_div: got %0d expected 271", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b expected 1", div_valid); end
    if (err_seen !== 0) begin miscompares++; $display("FAIL basic_err: got %0d expected 0", err_seen); end
    $display("test_basic_lock div_out=%0d", div_out);
  endtask

  task automatic test_wrong_char();
    int e0;
    rst_assert(); idle(3); rst_release(); idle(10);
    e0 = err_seen;
    send_char(8'h00, 100, 0, 1'b0, 10);
    drain();
    vectors += 3;
    if (err_seen - e0 !== 1) begin miscompares++; $display("FAIL wrong00_err: got %0d expected 1", err_seen - e0); end
    if (div_out !== DW'(DEF)) begin miscompares++; $display("FAIL wrong00_div: got %0d expected %0d", div_out, DEF); end
    if (div_valid !== 1'b0) begin miscompares++; $display("FAIL wrong00_valid: got %b expected 0", div_valid); end
    send_char(8'hF0, 100, 0, 1'b0, 10);
    idle(10);
    send_char(8'h55, 100, 0, 1'b0, 10);
    drain();
    vectors += 3;
    if (err_seen !== m_err) begin miscompares++; $display("FAIL wrongF0_err: got %0d expected %0d", err_seen, m_err); end
    if (div_out !== DW'(DEF)) begin miscompares++; $display("FAIL wrongF0_div: got %0d expected %0d", div_out, DEF); end
    if (div_valid !== 1'b0) begin miscompares++; $display("FAIL wrongF0_valid: got %b expected 0", div_valid); end
    $display("test_wrong_char errors=%0d", err_seen - e0);
  endtask

  task automatic test_below_min();
    int e0 = err_seen;
    idle(10);
    send_char(8'h55, 10, 0, 1'b0, 10);
    settle();
    vectors += 2;
    if (err_seen - e0 !== 1) begin miscompares++; $display("FAIL min10_err: got %0d expected 1", err_seen - e0); end
    if (div_valid !== 1'b0) begin miscompares++; $display("FAIL min10_valid: got %b expected 0", div_valid); end
    send_char(8'h55, 16, 0, 1'b0, 10);
    settle();
    vectors += 2;
    if (div_out !== 9'd16) begin miscompares++; $display("FAIL min16_div: got %0d expected 16", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL min16_valid: got %b expected 1", div_valid); end
    $display("test_below_min div_out=%0d", div_out);
  endtask

  task automatic test_relearn_jitter();
    pulse_relearn(); idle(10);
    send_char(8'h55, 271, 0, 1'b0, 10);
    settle();
    vectors += 2;
    if (div_out !== 9'd271) begin miscompares++; $display("FAIL relock271_div: got %0d expected 271", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL relock271_valid: got %b expected 1", div_valid); end
    send_char(8'h55, 100, 0, 1'b0, 10);
    settle();
    vectors += 2;
    if (div_out !== 9'd271) begin miscompares++; $display("FAIL locked_ignore_div: got %0d expected 271", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL locked_ignore_valid: got %b expected 1", div_valid); end
    pulse_relearn(); idle(10);
    send_char(8'h55, 100, 5, 1'b0, 10);
    settle();
    vectors += 3;
    if (div_out !== 9'd100) begin miscompares++; $display("FAIL jitter_div: got %0d expected 100", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL jitter_valid: got %b expected 1", div_valid); end
    if (err_seen !== m_err) begin miscompares++; $display("FAIL jitter_err: got %0d expected %0d", err_seen, m_err); end
    $display("test_relearn_jitter div_out=%0d", div_out);
  endtask

  task automatic test_timeout();
    int t0, elapsed;
    bit found = 1'b0;
    pulse_relearn(); idle(10);
    step(1'b0);
    t0 = cyc;
    elapsed = -1;
    for (int k = 0; k < T_TO + 200 && !found; k++) begin
      step(1'b0);
      @(negedge clk);
      if (sync_err === 1'b1) begin found = 1'b1; elapsed = cyc - t0; end
    end
    vectors++;
    if (!found || elapsed < T_TO - 2 || elapsed > T_TO + 2) begin
      miscompares++;
      $display("FAIL timeout_time: got %0d cycles expected %0d", elapsed, T_TO);
    end
    step(1'b1);
    settle();
    vectors += 3;
    if (err_seen !== m_err) begin miscompares++; $display("FAIL timeout_err: got %0d expected %0d", err_seen, m_err); end
    if (div_out !== 9'd100) begin miscompares++; $display("FAIL timeout_div: got %0d expected 100", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL timeout_valid: got %b expected 1", div_valid); end
    $display("test_timeout elapsed=%0d", elapsed);
  endtask

  task automatic test_reset_mid();
    pulse_relearn(); idle(10);
    send_char(8'h55, 200, 0, 1'b0, 4);
    rst_assert();
    idle(3);
    @(negedge clk);
    vectors += 4;
    if (rx_out !== 1'b1) begin miscompares++; $display("FAIL midrst_rx_out: got %b expected 1", rx_out); end
    if (div_out !== DW'(DEF)) begin miscompares++; $display("FAIL midrst_div: got %0d expected %0d", div_out, DEF); end
    if (div_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", div_valid); end
    if (sync_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b expected 0", sync_err); end
    rst_release();
    idle(10);
    send_char(8'h55, 200, 0, 1'b0, 10);
    settle();
    vectors += 2;
    if (div_out !== 9'd200) begin miscompares++; $display("FAIL midrst_relock_div: got %0d expected 200", div_out); end
    if (div_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_relock_valid: got %b expected 1", div_valid); end
    $display("test_reset_mid div_out=%0d", div_out);
  endtask

  task automatic test_random();
    logic [7:0] c;
    int p, jit;
    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(1) == 1) pulse_relearn();
      c   = ($urandom_range(1) == 1) ? 8'h55 : 8'($urandom);
      p   = int'($urandom_range(60, 16));
      jit = (p >= 40) ? int'($urandom_range(3)) : 0;
      send_char(c, p, jit, 1'b0, 10);
      idle(3 * p);
      settle();
      vectors += 3;
      if (div_out !== DW'(m_div)) begin miscompares++; $display("FAIL rand%0d_div: got %0d expected %0d", n, div_out, m_div); end
      if (div_valid !== 1'(m_valid)) begin miscompares++; $display("FAIL rand%0d_valid: got %b expected %0d", n, div_valid, m_valid); end
      if (err_seen !== m_err) begin miscompares++; $display("FAIL rand%0d_err: got %0d expected %0d", n, err_seen, m_err); end
      $display("rand %0d char=%h period=%0d jit=%0d div_out=%0d valid=%b errs=%0d", n, c, p, jit, div_out, div_valid, err_seen);
    end
    drain();
    vectors += 2;
    if (err_seen !== m_err) begin miscompares++; $display("FAIL rand_final_err: got %0d expected %0d", err_seen, m_err); end
    if (err_wide !== 0) begin miscompares++; $display("FAIL sync_err_width: got %0d long pulses expected 0", err_wide); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic_lock();
    test_wrong_char();
    test_below_min();
    test_relearn_jitter();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
